// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: one operand bit per clock through a two-half-adder
// bit cell, with a start/busy/done handshake and held sum/carry outputs.

module half_adder (
   input  logic a,
   input  logic b,
   output logic sum,
   output logic carry
);
   assign sum   = a ^ b;
   assign carry = a & b;
endmodule

module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             iCLK,
   input  logic             iRST,
   input  logic             iSTART,
   input  logic [WIDTH-1:0] iA,
   input  logic [WIDTH-1:0] iB,
   output logic             oBUSY,
   output logic             oDONE,
   output logic [WIDTH-1:0] oSUM,
   output logic             oCARRY
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] opa_q, opa_d;
   logic [WIDTH-1:0] opb_q, opb_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic ha1_sum, ha1_carry, ha2_sum, ha2_carry;
   logic bit_sum, bit_carry;
   logic last_bit;

   half_adder u_ha1 (.a(opa_q[0]), .b(opb_q[0]), .sum(ha1_sum), .carry(ha1_carry));
   half_adder u_ha2 (.a(ha1_sum),  .b(carry_q),  .sum(ha2_sum), .carry(ha2_carry));

   assign bit_sum   = ha2_sum;
   assign bit_carry = ha1_carry | ha2_carry;
   assign last_bit  = (cnt_q == CW'(WIDTH - 1));

   // State register
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) state_q <= S_IDLE;
      else      state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (iSTART) state_d = S_SHIFT;
         S_SHIFT: if (last_bit) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so the flags are registered
   always_comb begin
      busy_d = (state_d == S_SHIFT);
      done_d = (state_d == S_DONE);
   end

   always_comb begin
      opa_d   = opa_q;
      opb_d   = opb_q;
      acc_d   = acc_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      case (state_q)
         S_IDLE: begin
            if (iSTART) begin
               opa_d   = iA;
               opb_d   = iB;
               acc_d   = '0;
               carry_d = 1'b0;
               cnt_d   = '0;
            end
         end
         S_SHIFT: begin
            // LSB-first bits enter at the top and settle into place after WIDTH shifts
            acc_d   = {bit_sum, acc_q[WIDTH-1:1]};
            opa_d   = {1'b0, opa_q[WIDTH-1:1]};
            opb_d   = {1'b0, opb_q[WIDTH-1:1]};
            carry_d = bit_carry;
            cnt_d   = cnt_q + CW'(1);
            if (last_bit) begin
               sum_d  = {bit_sum, acc_q[WIDTH-1:1]};
               cout_d = bit_carry;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         opa_q   <= '0;
         opb_q   <= '0;
         acc_q   <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         acc_q   <= acc_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign oBUSY  = busy_q;
   assign oDONE  = done_q;
   assign oSUM   = sum_q;
   assign oCARRY = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: an arithmetic reference model checked every
// cycle, plus hand-computed literal results for each directed scenario.

module tb_serial_adder;
   localparam int W = 8;

   logic         iCLK = 1'b0;
   logic         iRST = 1'b1;
   logic         iSTART = 1'b0;
   logic [W-1:0] iA = '0;
   logic [W-1:0] iB = '0;
   logic         oBUSY, oDONE, oCARRY;
   logic [W-1:0] oSUM;

   int n_cmp = 0;
   int n_err = 0;
   int n_txn = 0;

   serial_adder #(.WIDTH(W)) dut (
      .iCLK(iCLK), .iRST(iRST), .iSTART(iSTART), .iA(iA), .iB(iB),
      .oBUSY(oBUSY), .oDONE(oDONE), .oSUM(oSUM), .oCARRY(oCARRY)
   );

   always #5 iCLK = ~iCLK;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Reference model: phase counts edges since the accepting edge (0 = idle).
   int           m_phase;
   logic [W:0]   m_pend;
   logic [W:0]   m_res;

   always @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         m_phase <= 0;
         m_pend  <= '0;
         m_res   <= '0;
      end else if (m_phase == 0) begin
         if (iSTART) begin
            m_phase <= 1;
            m_pend  <= {1'b0, iA} + {1'b0, iB};
         end
      end else begin
         m_phase <= (m_phase == W + 1) ? 0 : m_phase + 1;
         if (m_phase == W) m_res <= m_pend;
      end
   end

   always @(negedge iCLK) begin
      check("busy",  {31'd0, oBUSY}, {31'd0, (m_phase >= 1 && m_phase <= W)});
      check("done",  {31'd0, oDONE}, {31'd0, (m_phase == W + 1)});
      check("sum",   {24'd0, oSUM},  {24'd0, m_res[W-1:0]});
      check("carry", {31'd0, oCARRY}, {31'd0, m_res[W]});
      if (oDONE) begin
         n_txn++;
         $display("txn %0d: t=%0t sum=0x%02h carry=%0b", n_txn, $time, oSUM, oCARRY);
      end
   end

   // Runs a fixed 20-cycle window from one start; extra start pulses at p1/p2 use iA=0xFF.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input int p1, input int p2,
                         output int busy_n, output int done_k, output int done_n,
                         output logic [W-1:0] got_sum, output logic got_c);
      busy_n = 0; done_k = 0; done_n = 0; got_sum = '0; got_c = 1'b0;
      @(negedge iCLK);
      iA = a; iB = b; iSTART = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         @(negedge iCLK);
         iSTART = 1'b0;
         if (k == p1 || k == p2) begin
            iA = 8'hFF; iSTART = 1'b1;
         end
         if (oBUSY) busy_n++;
         if (oDONE) begin
            done_n++;
            if (done_k == 0) begin
               done_k  = k;
               got_sum = oSUM;
               got_c   = oCARRY;
            end
         end
      end
      iSTART = 1'b0;
   endtask

   task automatic directed(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] exp_sum, input logic exp_c,
                           input int p1, input int p2);
      int busy_n, done_k, done_n;
      logic [W-1:0] s;
      logic c;
      run_op(a, b, p1, p2, busy_n, done_k, done_n, s, c);
      check({name, ".sum"},    {24'd0, s}, {24'd0, exp_sum});
      check({name, ".carry"},  {31'd0, c}, {31'd0, exp_c});
      check({name, ".model"},  {23'd0, m_res}, {23'd0, exp_c, exp_sum});
      check({name, ".busy_n"}, busy_n, 8);
      check({name, ".done_k"}, done_k, 9);
      check({name, ".done_n"}, done_n, 1);
   endtask

   initial begin
      int dones;
      int first_k, last_k, gap_err;

      #1;
      check("rst.busy",  {31'd0, oBUSY}, 0);
      check("rst.done",  {31'd0, oDONE}, 0);
      check("rst.sum",   {24'd0, oSUM}, 0);
      check("rst.carry", {31'd0, oCARRY}, 0);
      repeat (2) @(negedge iCLK);
      iRST = 1'b0;

      directed("basic",   8'h5A, 8'h33, 8'h8D, 1'b0, 0, 0);
      directed("ripple1", 8'hFF, 8'h01, 8'h00, 1'b1, 0, 0);
      directed("ripple2", 8'hFF, 8'hFF, 8'hFE, 1'b1, 0, 0);
      directed("busystart", 8'h10, 8'h20, 8'h30, 1'b0, 3, 9);

      // Asynchronous reset in the fourth SHIFT cycle, between clock edges
      @(negedge iCLK);
      iA = 8'h5A; iB = 8'h33; iSTART = 1'b1;
      @(negedge iCLK);
      iSTART = 1'b0;
      repeat (3) @(negedge iCLK);
      @(posedge iCLK);
      #2 iRST = 1'b1;
      #1;
      check("arst.busy",  {31'd0, oBUSY}, 0);
      check("arst.done",  {31'd0, oDONE}, 0);
      check("arst.sum",   {24'd0, oSUM}, 0);
      check("arst.carry", {31'd0, oCARRY}, 0);
      @(negedge iCLK);
      @(negedge iCLK);
      iRST = 1'b0;
      dones = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge iCLK);
         if (oDONE) dones++;
      end
      check("arst.no_done", dones, 0);
      directed("after_rst", 8'h01, 8'h01, 8'h02, 1'b0, 0, 0);

      // Back-to-back: iSTART held high, operands changing every cycle
      dones = 0; first_k = 0; last_k = 0; gap_err = 0;
      @(negedge iCLK);
      iSTART = 1'b1;
      iA = 8'hC3; iB = 8'h5E;
      for (int k = 1; k <= 40; k++) begin
         @(negedge iCLK);
         iA = 8'((k * 37 + 11) & 8'hFF);
         iB = 8'((k * 91 + 5) & 8'hFF);
         if (oDONE) begin
            dones++;
            if (first_k == 0) begin
               first_k = k;
               check("b2b.first_sum", {23'd0, oCARRY, oSUM}, 32'h121);
            end else if (k - last_k != W + 2) begin
               gap_err++;
            end
            last_k = k;
         end
      end
      iSTART = 1'b0;
      check("b2b.first_k", first_k, 9);
      check("b2b.count", dones, 4);
      check("b2b.gap_err", gap_err, 0);
      repeat (3) @(negedge iCLK);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
